idu_ex_elastic_pipe: RTL and testbench

Parametrised elastic decode-to-execute pipeline buffer. It replaces the fixed, stall-gated ID/EX register with a DEPTH-entry valid/ready queue carrying an arbitrary-width decode payload. Payload fields include instruction address, register addresses, CSR addresses, decode bus, immediate, instruction word and flag bits. It sits between the IDU decode stage and the execute/dispatch stage. Decode may run ahead of a stalled execute without losing instructions, and a pipeline flush discards every buffered entry in one cycle.

---
 rtl/idu_ex_elastic_pipe.sv | 66 ++++++
 tb/tb_idu_ex_elastic_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/idu_ex_elastic_pipe.sv
// Elastic decode-to-execute buffer: DEPTH-entry valid/ready queue with single-cycle flush.
// Bubbles and flushed outputs carry an all-zero payload, matching a flushed ID/EX register.
module idu_ex_elastic_pipe #(
    parameter int DATA_W = 192,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // The extra MSB on each pointer is a wrap bit that separates full from empty.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Ready and valid depend only on stored state and flush, never on the far side's handshake.
    assign s_ready_o = ~full_o & ~flush_i;
    assign m_valid_o = ~empty_o & ~flush_i;
    assign m_data_o  = m_valid_o ? mem[rd_ptr[AW-1:0]] : '0;

    assign push = s_valid_i & s_ready_o;
    assign pop  = m_valid_o & m_ready_i;

    // For power-of-two DEPTH, CNT_W equals PTR_W, so the modular pointer difference is the count.
    assign count_o = CNT_W'(wr_ptr - rd_ptr);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the payload array has no reset; stale entries are never visible because the
    // output is masked whenever the queue is empty or being flushed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_data_i;
    end

endmodule

// File: tb/tb_idu_ex_elastic_pipe.sv
// Directed bench for idu_ex_elastic_pipe: three instances cover wide/shallow, flush at DEPTH=4,
// and a 1-bit/DEPTH=8 sweep.
module tb_idu_ex_elastic_pipe;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Instance A: DATA_W=256, DEPTH=2
    logic         a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_empty, a_full;
    logic [255:0] a_s_data, a_m_data;
    logic [1:0]   a_count;

    // Instance B: DATA_W=8, DEPTH=4
    logic         b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_empty, b_full;
    logic [7:0]   b_s_data, b_m_data;
    logic [2:0]   b_count;

    // Instance C: DATA_W=1, DEPTH=8
    logic         c_flush, c_s_valid, c_s_ready, c_m_valid, c_m_ready, c_empty, c_full;
    logic [0:0]   c_s_data, c_m_data;
    logic [3:0]   c_count;

    idu_ex_elastic_pipe #(.DATA_W(256), .DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
        .s_valid_i(a_s_valid), .s_ready_o(a_s_ready), .s_data_i(a_s_data),
        .m_valid_o(a_m_valid), .m_ready_i(a_m_ready), .m_data_o(a_m_data),
        .count_o(a_count), .empty_o(a_empty), .full_o(a_full)
    );

    idu_ex_elastic_pipe #(.DATA_W(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
        .s_valid_i(b_s_valid), .s_ready_o(b_s_ready), .s_data_i(b_s_data),
        .m_valid_o(b_m_valid), .m_ready_i(b_m_ready), .m_data_o(b_m_data),
        .count_o(b_count), .empty_o(b_empty), .full_o(b_full)
    );

    idu_ex_elastic_pipe #(.DATA_W(1), .DEPTH(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush_i(c_flush),
        .s_valid_i(c_s_valid), .s_ready_o(c_s_ready), .s_data_i(c_s_data),
        .m_valid_o(c_m_valid), .m_ready_i(c_m_ready), .m_data_o(c_m_data),
        .count_o(c_count), .empty_o(c_empty), .full_o(c_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Replicate a 32-bit tag across the wide payload so truncation anywhere shows up.
    function automatic logic [255:0] mk(input logic [31:0] v);
        return {8{v}};
    endfunction

    task automatic test_reset;
        @(negedge clk);
        a_m_ready = 1'b0; a_s_valid = 1'b1; a_s_data = mk(32'h1);
        @(negedge clk);
        a_s_data = mk(32'h2);
        @(negedge clk);
        a_s_valid = 1'b0;
        n_checks++; if (a_count !== 2'd2) begin n_fail++; $display("FAIL reset_precount: got %0d want 2", a_count); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_count); end
        n_checks++; if (a_m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", a_m_valid); end
        n_checks++; if (a_m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", a_m_data); end
        n_checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty %b full %b want 1 0", a_empty, a_full); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", a_s_ready); end
        n_checks++; if (b_count !== 3'd0 || c_count !== 4'd0) begin n_fail++; $display("FAIL reset_other_counts: got %0d %0d want 0 0", b_count, c_count); end
    endtask

    task automatic test_fill_drain;
        @(negedge clk);
        a_m_ready = 1'b0; a_s_valid = 1'b1; a_s_data = mk(32'hA);
        @(negedge clk);
        n_checks++; if (a_m_valid !== 1'b1 || a_m_data !== mk(32'hA)) begin n_fail++; $display("FAIL fill_head_a: valid %b data %h want 1 A", a_m_valid, a_m_data[31:0]); end
        a_s_data = mk(32'hB);
        @(negedge clk);
        n_checks++; if (a_full !== 1'b1 || a_s_ready !== 1'b0 || a_count !== 2'd2) begin n_fail++; $display("FAIL fill_full: full %b ready %b count %0d want 1 0 2", a_full, a_s_ready, a_count); end
        a_s_data = mk(32'hC);
        @(negedge clk);
        n_checks++; if (a_count !== 2'd2 || a_m_data !== mk(32'hA)) begin n_fail++; $display("FAIL fill_refuse_c: count %0d head %h want 2 A", a_count, a_m_data[31:0]); end
        a_m_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (a_m_data !== mk(32'hB) || a_count !== 2'd1 || a_s_ready !== 1'b1) begin n_fail++; $display("FAIL drain_b: head %h count %0d ready %b want B 1 1", a_m_data[31:0], a_count, a_s_ready); end
        @(negedge clk);
        n_checks++; if (a_m_data !== mk(32'hC) || a_count !== 2'd1) begin n_fail++; $display("FAIL drain_c: head %h count %0d want C 1", a_m_data[31:0], a_count); end
        a_s_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (a_empty !== 1'b1 || a_m_valid !== 1'b0 || a_m_data !== '0) begin n_fail++; $display("FAIL drain_bubble: empty %b valid %b data %h want 1 0 0", a_empty, a_m_valid, a_m_data[31:0]); end
        a_m_ready = 1'b0;
    endtask

    task automatic test_streaming;
        @(negedge clk);
        a_m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (a_m_data !== mk(32'(i - 1)) || a_count !== 2'd1 || a_m_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stream_%0d: head %h count %0d want %0d 1", i - 1, a_m_data[31:0], a_count, i - 1);
                end
            end
            a_s_valid = 1'b1; a_s_data = mk(32'(i));
            @(negedge clk);
        end
        n_checks++; if (a_m_data !== mk(32'd16) || a_count !== 2'd1) begin n_fail++; $display("FAIL stream_16: head %h count %0d want 16 1", a_m_data[31:0], a_count); end
        a_s_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (a_empty !== 1'b1 || a_m_data !== '0) begin n_fail++; $display("FAIL stream_end: empty %b data %h want 1 0", a_empty, a_m_data[31:0]); end
        a_m_ready = 1'b0;
    endtask

    task automatic test_flush;
        @(negedge clk);
        b_m_ready = 1'b0; b_s_valid = 1'b1; b_s_data = 8'h11;
        @(negedge clk); b_s_data = 8'h22;
        @(negedge clk); b_s_data = 8'h33;
        @(negedge clk);
        n_checks++; if (b_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre: count %0d want 3", b_count); end
        b_flush = 1'b1; b_s_data = 8'h44; b_m_ready = 1'b1;
        #1;
        n_checks++; if (b_m_valid !== 1'b0 || b_s_ready !== 1'b0 || b_m_data !== 8'h00) begin n_fail++; $display("FAIL flush_cycle: valid %b ready %b data %h want 0 0 00", b_m_valid, b_s_ready, b_m_data); end
        @(negedge clk);
        b_flush = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b0;
        #1;
        n_checks++; if (b_count !== 3'd0 || b_empty !== 1'b1 || b_m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: count %0d empty %b valid %b want 0 1 0", b_count, b_empty, b_m_valid); end
        @(negedge clk);
        b_s_valid = 1'b1; b_s_data = 8'h55;
        @(negedge clk);
        b_s_valid = 1'b0;
        n_checks++; if (b_m_data !== 8'h55 || b_count !== 3'd1) begin n_fail++; $display("FAIL flush_next_head: head %h count %0d want 55 1", b_m_data, b_count); end
        b_m_ready = 1'b1;
        @(negedge clk);
        b_m_ready = 1'b0;
        n_checks++; if (b_empty !== 1'b1) begin n_fail++; $display("FAIL flush_drain: empty %b want 1", b_empty); end
    endtask

    task automatic test_backpressure;
        logic [7:0] q[$];
        for (int i = 0; i < 10008; i++) begin
            @(negedge clk);
            n_checks++;
            if (b_count !== 3'(q.size()) || b_count > 3'd4 || b_m_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL bp_occupancy cycle %0d: count %0d valid %b want %0d", i, b_count, b_m_valid, q.size());
            end
            b_s_valid = (i < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_s_data  = 8'($urandom);
            b_m_ready = (i < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (b_m_valid && b_m_ready) begin
                n_checks++;
                if (q.size() == 0 || b_m_data !== q[0]) begin
                    n_fail++; $display("FAIL bp_order cycle %0d: got %h want %h", i, b_m_data, (q.size() != 0) ? q[0] : 8'h00);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (b_s_valid && b_s_ready) q.push_back(b_s_data);
        end
        b_s_valid = 1'b0; b_m_ready = 1'b0;
        n_checks++; if (q.size() != 0 || b_empty !== 1'b1) begin n_fail++; $display("FAIL bp_final: left %0d empty %b want 0 1", q.size(), b_empty); end
    endtask

    task automatic test_sweep_narrow_deep;
        logic [7:0] pat;
        pat = 8'b0100_1101;
        @(negedge clk);
        c_m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c_s_valid = 1'b1; c_s_data = pat[i];
            @(negedge clk);
        end
        c_s_valid = 1'b1; c_s_data = 1'b0;
        #1;
        n_checks++; if (c_count !== 4'd8 || c_full !== 1'b1 || c_s_ready !== 1'b0) begin n_fail++; $display("FAIL sweep_full: count %0d full %b ready %b want 8 1 0", c_count, c_full, c_s_ready); end
        @(negedge clk);
        c_s_valid = 1'b0; c_m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (c_m_valid !== 1'b1 || c_m_data !== pat[i] || c_count !== 4'(8 - i)) begin
                n_fail++; $display("FAIL sweep_pop_%0d: valid %b data %b count %0d want 1 %b %0d", i, c_m_valid, c_m_data, c_count, pat[i], 8 - i);
            end
            @(negedge clk);
        end
        c_m_ready = 1'b0;
        n_checks++; if (c_empty !== 1'b1 || c_m_valid !== 1'b0 || c_m_data !== 1'b0) begin n_fail++; $display("FAIL sweep_bubble: empty %b valid %b data %b want 1 0 0", c_empty, c_m_valid, c_m_data); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        a_flush = 1'b0; a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0;
        b_flush = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
        c_flush = 1'b0; c_s_valid = 1'b0; c_s_data = '0; c_m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_fill_drain();
        test_streaming();
        test_flush();
        test_backpressure();
        test_sweep_narrow_deep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
